apa102_rx: RTL

- Receiver and decoder for the APA102 LED-strip serial stream produced by the existing LED-strip driver.
- Samples led_clk/led_data from a pin or loopback, recovers 32-bit words MSB-first and classifies them as start-of-frame, pixel or end-of-frame.
- Emits one-cycle pixel strobes with index and colour, plus frame-done and error strobes.
- Used for hardware loopback self-test of the LED path and for daisy-chain monitoring.

---
 rtl/apa102_pkg.sv | 30 +++
 rtl/apa102_rx_if.sv | 35 +++
 rtl/apa102_rx_sync.sv | 51 +++++
 rtl/apa102_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
`default_nettype none
// ============================================================================
// apa102_pkg : shared APA102 word constants, field offsets and receiver states
// Revision   : 1.0
// ============================================================================
package apa102_pkg;

  // Command words shared by the LED-strip driver and the receiver
  localparam logic [31:0] APA102_CMD_SOF       = 32'h0000_0000;
  localparam logic [31:0] APA102_CMD_EOF       = 32'hFFFF_FFFF;
  localparam logic [2:0]  APA102_CMD_PIXEL_HDR = 3'b111;

  localparam logic [31:0] APA102_SOF_WORD  = APA102_CMD_SOF;
  localparam logic [31:0] APA102_EOF_WORD  = APA102_CMD_EOF;
  localparam logic [2:0]  APA102_PIXEL_HDR = APA102_CMD_PIXEL_HDR;

  localparam int APA102_HDR_LSB    = 29;
  localparam int APA102_BRIGHT_LSB = 24;
  localparam int APA102_BLUE_LSB   = 16;
  localparam int APA102_GREEN_LSB  = 8;
  localparam int APA102_RED_LSB    = 0;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    FRAME = 2'd1,
    TAIL  = 2'd2
  } apa102_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/apa102_rx_if.sv
`default_nettype none
// ============================================================================
// apa102_rx_if : APA102 serial input pair plus decoded pixel/frame outputs
// Revision     : 1.0
// ============================================================================
interface apa102_rx_if #(
  parameter int IDX_W = 16
);
  logic             led_clk;
  logic             led_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_index;
  logic [4:0]       pixel_bright;
  logic [7:0]       pixel_blue;
  logic [7:0]       pixel_green;
  logic [7:0]       pixel_red;
  logic             frame_done;
  logic [IDX_W-1:0] frame_pixels;
  logic             error;
  logic             in_frame;

  // master is the stream source, slave is the receiver
  modport master (
    output led_clk, led_data,
    input  pixel_valid, pixel_index, pixel_bright, pixel_blue, pixel_green,
           pixel_red, frame_done, frame_pixels, error, in_frame
  );

  modport slave (
    input  led_clk, led_data,
    output pixel_valid, pixel_index, pixel_bright, pixel_blue, pixel_green,
           pixel_red, frame_done, frame_pixels, error, in_frame
  );
endinterface
`default_nettype wire

// File: rtl/apa102_rx_sync.sv
`default_nettype none
// ============================================================================
// apa102_rx_sync : N-flop synchroniser and led_clk rising-edge detector
// Revision       : 1.0
// ============================================================================
module apa102_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic led_clk,
  input  logic led_data,
  output logic bit_strobe,
  output logic bit_value
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   bit_strobe_q, bit_strobe_d;
  logic                   bit_value_q, bit_value_d;

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], led_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], led_data};
    clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
    bit_strobe_d = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    bit_value_d  = data_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q   <= '0;
      data_sync_q  <= '0;
      clk_prev_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      bit_value_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      bit_strobe_q <= bit_strobe_d;
      bit_value_q  <= bit_value_d;
    end
  end

  assign bit_strobe = bit_strobe_q;
  assign bit_value  = bit_value_q;

endmodule
`default_nettype wire

// File: rtl/apa102_rx.sv
`default_nettype none
// ============================================================================
// apa102_rx : APA102 stream receiver - word recovery, classification, strobes
// Revision  : 1.0
// ============================================================================
module apa102_rx
  import apa102_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int IDX_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  apa102_rx_if.slave  bus
);

  localparam int                TMO_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(IDLE_TIMEOUT);

  logic bit_strobe, bit_value;

  apa102_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_clk    (bus.led_clk),
    .led_data   (bus.led_data),
    .bit_strobe (bit_strobe),
    .bit_value  (bit_value)
  );

  apa102_rx_state_t   state_q, state_d;
  logic [31:0]        shift_q, shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               eval_q, eval_d;
  logic               word_rdy_q, word_rdy_d;
  logic [IDX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0]   pixel_index_q, pixel_index_d;
  logic [4:0]         bright_q, bright_d;
  logic [7:0]         blue_q, blue_d, green_q, green_d, red_q, red_d;
  logic               frame_done_q, frame_done_d;
  logic [IDX_W-1:0]   frame_pixels_q, frame_pixels_d;
  logic               error_q, error_d;
  logic               in_frame_q, in_frame_d;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    eval_d         = 1'b0;
    word_rdy_d     = 1'b0;
    pix_cnt_d      = pix_cnt_q;
    tmo_d          = tmo_q;
    pixel_valid_d  = 1'b0;
    pixel_index_d  = pixel_index_q;
    bright_d       = bright_q;
    blue_d         = blue_q;
    green_d        = green_q;
    red_d          = red_q;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    error_d        = 1'b0;

    // Bit intake: the window is evaluated on the cycle after each shift
    if (bit_strobe) begin
      shift_d = {shift_q[30:0], bit_value};
      eval_d  = 1'b1;
      tmo_d   = '0;
      if (state_q == FRAME) begin
        bit_cnt_d  = bit_cnt_q + 5'd1;
        word_rdy_d = (bit_cnt_q == 5'd31);
      end
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    // An all-zero window realigns in every state, which also absorbs
    // leading zeros longer than one word
    if (eval_q) begin
      if (shift_q == APA102_SOF_WORD) begin
        state_d   = FRAME;
        bit_cnt_d = '0;
        pix_cnt_d = '0;
      end else if (state_q == FRAME && word_rdy_q) begin
        if (shift_q == APA102_EOF_WORD) begin
          frame_done_d   = 1'b1;
          frame_pixels_d = pix_cnt_q;
          state_d        = TAIL;
        end else if (shift_q[APA102_HDR_LSB +: 3] == APA102_PIXEL_HDR) begin
          pixel_valid_d = 1'b1;
          pixel_index_d = pix_cnt_q;
          bright_d      = shift_q[APA102_BRIGHT_LSB +: 5];
          blue_d        = shift_q[APA102_BLUE_LSB +: 8];
          green_d       = shift_q[APA102_GREEN_LSB +: 8];
          red_d         = shift_q[APA102_RED_LSB +: 8];
          if (pix_cnt_q != '1) begin
            pix_cnt_d = pix_cnt_q + IDX_W'(1);
          end
        end else begin
          error_d = 1'b1;
          state_d = HUNT;
        end
      end
    end else if (tmo_q == TMO_MAX) begin
      error_d   = (state_q == FRAME);
      state_d   = HUNT;
      bit_cnt_d = '0;
    end

    in_frame_d = (state_d == FRAME) || (state_d == TAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      shift_q        <= '1;
      bit_cnt_q      <= '0;
      eval_q         <= 1'b0;
      word_rdy_q     <= 1'b0;
      pix_cnt_q      <= '0;
      tmo_q          <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_index_q  <= '0;
      bright_q       <= '0;
      blue_q         <= '0;
      green_q        <= '0;
      red_q          <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      error_q        <= 1'b0;
      in_frame_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      eval_q         <= eval_d;
      word_rdy_q     <= word_rdy_d;
      pix_cnt_q      <= pix_cnt_d;
      tmo_q          <= tmo_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_index_q  <= pixel_index_d;
      bright_q       <= bright_d;
      blue_q         <= blue_d;
      green_q        <= green_d;
      red_q          <= red_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      error_q        <= error_d;
      in_frame_q     <= in_frame_d;
    end
  end

  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.pixel_index  = pixel_index_q;
  assign bus.pixel_bright = bright_q;
  assign bus.pixel_blue   = blue_q;
  assign bus.pixel_green  = green_q;
  assign bus.pixel_red    = red_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_pixels = frame_pixels_q;
  assign bus.error        = error_q;
  assign bus.in_frame     = in_frame_q;

endmodule
`default_nettype wire
